// File: rtl/mcp320x_pkg.sv
// -----------------------------------------------------------------------------
// mcp320x_pkg
// Shared types, frame constants and channel-selection helpers for the
// MCP3204/MCP3208 scanning SPI master.
//   state_t     : controller state encoding
//   ch_sel_t    : {done, ch} result of a channel search
//   next_ch()   : next enabled channel above the current one, or done
//   first_ch()  : lowest enabled channel, or done when the mask is empty
//   mosi_bit()  : command bit driven on MOSI during SCK cycle k
// -----------------------------------------------------------------------------
package mcp320x_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_XFER,
      S_GAP
   } state_t;

   // One conversion frame: start, SGL/DIFF, D2..D0, sample, null, B11..B0.
   localparam int FRAME_SCK  = 19;
   localparam int CMD_BITS   = 5;
   localparam int DATA_LSB_K = FRAME_SCK - 1;
   localparam int DATA_MSB_K = DATA_LSB_K - 11;

   typedef struct packed {
      logic       done;
      logic [2:0] ch;
   } ch_sel_t;

   // Lowest set bit of mask at or above lo; done=1 when none exists.
   function automatic ch_sel_t scan_from(input logic [7:0] mask, input int lo);
      ch_sel_t sel;
      sel.done = 1'b1;
      sel.ch   = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (i >= lo && mask[3'(i)]) begin
            sel.done = 1'b0;
            sel.ch   = 3'(i);
         end
      end
      return sel;
   endfunction

   function automatic ch_sel_t next_ch(input logic [7:0] mask, input logic [2:0] cur);
      return scan_from(mask, int'(cur) + 1);
   endfunction

   function automatic ch_sel_t first_ch(input logic [7:0] mask);
      return scan_from(mask, 0);
   endfunction

   function automatic logic mosi_bit(input logic [4:0] k, input logic [2:0] c,
                                     input logic sgl);
      if (k >= 5'(CMD_BITS)) return 1'b0;
      case (k[2:0])
         3'd0:    return 1'b1;
         3'd1:    return sgl;
         3'd2:    return c[2];
         3'd3:    return c[1];
         3'd4:    return c[0];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mcp320x_tick_gen.sv
// -----------------------------------------------------------------------------
// mcp320x_tick_gen
// Free-running sample-period counter 0..TPER-1; emits a one-clock tick on the
// last count while enabled. Dropping en clears the count.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable
//   tick       : one-clock strobe at count TPER-1
// -----------------------------------------------------------------------------
module mcp320x_tick_gen #(
   parameter int TPER = 200000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CW = (TPER > 1) ? $clog2(TPER) : 1;
   localparam logic [CW-1:0] LAST = CW'(TPER - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!en || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/mcp320x_scan_spi.sv
// -----------------------------------------------------------------------------
// mcp320x_scan_spi
// SPI master for MCP3204/MCP3208 that scans the enabled channels once per
// sample period and streams 12-bit results tagged with their channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : scan enable (level)
//   ch_mask    : channel enables, bits >= NCH ignored, latched per scan
//   miso       : ADC Dout
//   mosi, sck, cs : ADC Din, SPI clock (mode 0,0), active-low chip select
//   data, ch, dv  : result, its channel, one-clock valid strobe
//   busy       : scan in progress
//   overrun    : sticky, a period tick arrived during a scan
// -----------------------------------------------------------------------------
module mcp320x_scan_spi
   import mcp320x_pkg::*;
#(
   parameter int FCLK      = 100_000_000,
   parameter int FSMPL     = 500,
   parameter int SCK_DIV   = 900,
   parameter int NCH       = 4,
   parameter int DIFF      = 0,
   parameter int TCSH_CLKS = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [7:0]  ch_mask,
   input  logic        miso,
   output logic        mosi,
   output logic        sck,
   output logic        cs,
   output logic [11:0] data,
   output logic [2:0]  ch,
   output logic        dv,
   output logic        busy,
   output logic        overrun
);

   localparam int TPER  = FCLK / FSMPL;
   localparam int PH_W  = $clog2(SCK_DIV);
   localparam int GAP_W = $clog2(TCSH_CLKS + 1);

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCK_DIV - 1);
   // SCK rises on the edge that leaves the last low-phase count.
   localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(SCK_DIV / 2 - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TCSH_CLKS);
   localparam logic [7:0]       NCH_MASK = 8'((1 << NCH) - 1);
   localparam logic             SGL      = (DIFF == 0);

   state_t          state;
   logic [PH_W-1:0] ph;
   logic [4:0]      k;
   logic [GAP_W-1:0] gap_cnt;
   logic [7:0]      mask_lat;
   logic [2:0]      cur_ch;
   logic [11:0]     sreg;
   logic            tick;
   logic [7:0]      eff_mask;
   ch_sel_t         first_sel;
   ch_sel_t         gap_sel;

   mcp320x_tick_gen #(
      .TPER (TPER)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .tick  (tick)
   );

   assign eff_mask = ch_mask & NCH_MASK;

   always_comb begin
      first_sel = first_ch(eff_mask);
      gap_sel   = next_ch(mask_lat, cur_ch);
   end

   // NOTE: every register in this block uses <= so all next-state decisions
   // read the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cs       <= 1'b1;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         data     <= '0;
         ch       <= '0;
         dv       <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
         ph       <= '0;
         k        <= '0;
         gap_cnt  <= '0;
         mask_lat <= '0;
         cur_ch   <= '0;
         sreg     <= '0;
      end else begin
         dv <= 1'b0;
         if (tick && state != S_IDLE) overrun <= 1'b1;

         unique case (state)
            S_IDLE: begin
               // An empty effective mask leaves the tick unused.
               if (tick && !first_sel.done) begin
                  mask_lat <= eff_mask;
                  cur_ch   <= first_sel.ch;
                  state    <= S_SETUP;
                  busy     <= 1'b1;
                  cs       <= 1'b0;
                  mosi     <= 1'b1;
                  ph       <= '0;
                  k        <= '0;
               end
            end

            S_SETUP: state <= S_XFER;

            S_XFER: begin
               if (ph == PH_LAST) begin
                  ph  <= '0;
                  sck <= 1'b0;
                  if (k == 5'(DATA_LSB_K)) begin
                     state   <= S_GAP;
                     cs      <= 1'b1;
                     mosi    <= 1'b0;
                     dv      <= 1'b1;
                     data    <= sreg;
                     ch      <= cur_ch;
                     gap_cnt <= '0;
                  end else begin
                     // MOSI moves with the falling SCK edge, ahead of the next rise.
                     k    <= k + 5'd1;
                     mosi <= mosi_bit(k + 5'd1, cur_ch, SGL);
                  end
               end else begin
                  ph <= ph + PH_W'(1);
                  if (ph == PH_RISE) begin
                     sck <= 1'b1;
                     if (k >= 5'(DATA_MSB_K)) sreg <= {sreg[10:0], miso};
                  end
               end
            end

            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (gap_sel.done) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cur_ch <= gap_sel.ch;
                     state  <= S_SETUP;
                     cs     <= 1'b0;
                     mosi   <= 1'b1;
                     ph     <= '0;
                     k      <= '0;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mcp320x_scan_spi.sv
// -----------------------------------------------------------------------------
// tb_mcp320x_scan_spi
// Scoreboard bench: a period/scan-time model pushes expected {ch,data} results
// at each accepted tick; a monitor pops them on dv. An ADC model answers the
// command bits it decodes from MOSI. A second instance (DIFF=1, channel 6)
// covers the pseudo-differential command encoding.
// -----------------------------------------------------------------------------
module tb_mcp320x_scan_spi;
   import mcp320x_pkg::*;

   localparam int T_FCLK  = 30000;
   localparam int T_FSMPL = 100;
   localparam int TPER    = T_FCLK / T_FSMPL;        // 300 clocks
   localparam int DIV     = 4;
   localparam int T_NCH   = 4;
   localparam int TCSH    = 3;
   localparam int C       = FRAME_SCK * DIV + TCSH + 2; // 81 clocks per channel

   typedef struct packed {
      logic [2:0]  ch;
      logic [11:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic [7:0]  ch_mask = 8'h00;
   logic        miso = 1'b0;
   logic        mosi, sck, cs, dv, busy, overrun;
   logic [11:0] data;
   logic [2:0]  ch;
   logic        mosi_d, sck_d, cs_d, dv_d, busy_d, ovr_d;
   logic [11:0] data_d;
   logic [2:0]  ch_d;

   logic [11:0] adc_val [8];
   exp_t        exp_q [$];
   int          per_cnt = 0, busy_left = 0, scan_len = 0;
   logic        exp_ovr = 1'b0;
   int          rc = 0, rc_d = 0;
   logic [4:0]  cmd = '0, cmd_d = '0;
   int          total = 0, bad = 0;

   mcp320x_scan_spi #(
      .FCLK(T_FCLK), .FSMPL(T_FSMPL), .SCK_DIV(DIV), .NCH(T_NCH), .DIFF(0), .TCSH_CLKS(TCSH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .miso(miso),
      .mosi(mosi), .sck(sck), .cs(cs), .data(data), .ch(ch), .dv(dv),
      .busy(busy), .overrun(overrun)
   );

   mcp320x_scan_spi #(
      .FCLK(T_FCLK), .FSMPL(T_FSMPL), .SCK_DIV(DIV), .NCH(8), .DIFF(1), .TCSH_CLKS(TCSH)
   ) dut_d (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(8'h40), .miso(1'b0),
      .mosi(mosi_d), .sck(sck_d), .cs(cs_d), .data(data_d), .ch(ch_d), .dv(dv_d),
      .busy(busy_d), .overrun(ovr_d)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: period counter and scan occupancy as plain arithmetic.
   initial begin
      logic       tk;
      logic [7:0] m;
      int         n;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            per_cnt = 0; busy_left = 0; scan_len = 0; exp_ovr = 1'b0;
            exp_q.delete();
         end else begin
            tk = en && (per_cnt == TPER - 1);
            per_cnt = (!en || per_cnt == TPER - 1) ? 0 : per_cnt + 1;
            if (busy_left > 0) begin
               busy_left--;
               if (tk) exp_ovr = 1'b1;
            end else if (tk) begin
               m = ch_mask & 8'((1 << T_NCH) - 1);
               n = 0;
               for (int i = 0; i < 8; i++) begin
                  if (m[i]) begin
                     exp_q.push_back('{ch: 3'(i), data: adc_val[i]});
                     n++;
                  end
               end
               scan_len  = n * C;
               busy_left = scan_len;
            end
         end
      end
   end

   // Frame monitor: count SCK rises per CS-low window, capture command bits.
   initial forever begin
      @(posedge sck or negedge cs);
      if (sck) begin
         if (rc < CMD_BITS) cmd = {cmd[3:0], mosi};
         rc++;
      end else begin
         rc = 0; cmd = '0;
      end
   end

   initial forever begin
      @(posedge sck_d or negedge cs_d);
      if (sck_d) begin
         if (rc_d < CMD_BITS) cmd_d = {cmd_d[3:0], mosi_d};
         rc_d++;
      end else begin
         rc_d = 0; cmd_d = '0;
      end
   end

   // ADC model: shifts B11..B0 of the addressed channel out on falling SCK.
   initial begin
      logic [11:0] v;
      forever begin
         @(negedge sck or negedge cs);
         if (!cs && rc >= 7 && rc <= DATA_LSB_K) begin
            v = adc_val[cmd[2:0]] >> (DATA_LSB_K - rc);
            miso = v[0];
         end else begin
            miso = 1'b0;
         end
      end
   end

   initial forever begin
      @(posedge cs);
      if (rst_n === 1'b1) begin
         check("sck_rises", 32'(rc), 32'(FRAME_SCK));
         check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("cmd_bits", 32'(cmd), 32'({2'b11, exp_q[0].ch}));
      end
   end

   initial forever begin
      @(posedge cs_d);
      if (rst_n === 1'b1) begin
         check("diff_sck_rises", 32'(rc_d), 32'(FRAME_SCK));
         check("diff_cmd_bits", 32'(cmd_d), 32'(5'b10110));
      end
   end

   // Cycle monitor: busy/cs/dv/overrun against the model, results from the queue.
   initial begin
      logic exp_busy, exp_cs, exp_dv;
      int   pos;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            exp_busy = busy_left > 0;
            pos      = (scan_len - busy_left) % C;
            exp_cs   = !(exp_busy && pos <= FRAME_SCK * DIV);
            exp_dv   = exp_busy && (pos == FRAME_SCK * DIV + 1);
            check("busy", 32'(busy), 32'(exp_busy));
            check("cs", 32'(cs), 32'(exp_cs));
            check("dv", 32'(dv), 32'(exp_dv));
            check("overrun", 32'(overrun), 32'(exp_ovr));
            if (dv === 1'b1) begin
               check("dv_pending", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("result", 32'({ch, data}), 32'({e.ch, e.data}));
               end
            end
            if (dv_d === 1'b1) check("diff_result", 32'({ch_d, data_d}), 32'({3'd6, 12'd0}));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] m;
      int         w, lowc;
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
      adc_val[0] = 12'hA5C;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctrl", 32'({cs, sck, mosi, dv, busy, overrun}), 32'(6'b100000));
      check("rst_data", 32'(data), 32'd0);
      check("rst_ch", 32'(ch), 32'd0);
      rst_n = 1'b1;

      // Single channel 0, known ADC word.
      ch_mask = 8'h01; en = 1'b1;
      repeat (2 * TPER) @(negedge clk);

      // Random masks (at most three low channels, so no overrun), random en drops.
      for (int it = 0; it < 16; it++) begin
         m = 8'($urandom);
         if (m[3:0] == 4'hF) m = m & ~(8'h01 << $urandom_range(0, 3));
         if (it == 1) m = 8'h0A;
         ch_mask = m;
         en = ($urandom_range(0, 7) != 0);
         repeat ($urandom_range(100, 700)) @(negedge clk);
      end
      en = 1'b1;

      // Full mask costs 4*C > TPER: overrun sets, results stay ordered.
      ch_mask = 8'h0F;
      repeat (3 * TPER) @(negedge clk);
      check("overrun_set", 32'(overrun), 32'd1);

      // Reset in the middle of a frame (k=10).
      ch_mask = 8'h03;
      w = 0;
      while (!(rc == 10 && cs == 1'b0) && w < 4 * TPER) begin
         @(posedge clk);
         w++;
      end
      check("k10_reached", 32'(rc == 10 && cs == 1'b0), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_async_cs", 32'(cs), 32'd1);
      check("rst_async_sck", 32'(sck), 32'd0);
      check("rst_async_flags", 32'({dv, busy, overrun}), 32'd0);
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Clean restart with random masks.
      for (int it = 0; it < 4; it++) begin
         m = 8'($urandom_range(1, 15));
         if (m[3:0] == 4'hF) m = 8'h07;
         ch_mask = m;
         repeat (TPER) @(negedge clk);
      end

      // Empty mask: no activity over three periods once the last scan drains.
      ch_mask = 8'h00;
      repeat (TPER + 100) @(negedge clk);
      lowc = 0;
      repeat (3 * TPER) begin
         @(negedge clk);
         if (cs !== 1'b1 || busy !== 1'b0) lowc++;
      end
      check("mask0_idle", 32'(lowc), 32'd0);

      en = 1'b0;
      repeat (4 * C) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("diff_no_overrun", 32'(ovr_d), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mcp320x_scan_spi.md
# mcp320x_scan_spi

Parametrised SPI master for the MCP3204/MCP3208 family. It scans a programmable set of up to 8 input channels once per sample period and returns each 12-bit result tagged with its channel number. It replaces the single-channel, fixed-divider MCP3202 master in the ECG acquisition front end. Downstream filtering consumes the `dv`/`data`/`ch` stream.

## Interface
- `FCLK`, 100e6: input clock frequency in Hz.
- `FSMPL`, 500: scan rate in Hz. Scan period `TPER = FCLK/FSMPL` clocks.
- `SCK_DIV`, 900: clk cycles per SCK period. Must be even and ≥ 4.
- `NCH`, 4: number of channels scanned per period, 1..8.
- `DIFF`, 0: 0 selects single-ended (SGL=1); 1 selects pseudo-differential (SGL=0).
- `TCSH_CLKS`, 50: minimum CS-high clocks between conversions. Must be ≥ 1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `en`  in  1  scan enable, level-sensitive.
- `ch_mask`  in  8  channel n is skipped when `ch_mask[n]`=0. Bits ≥ NCH are ignored.
- `miso`  in  1  ADC Dout.
- `mosi`  out  1  ADC Din.
- `sck`  out  1  SPI clock, mode 0,0 (idle low).
- `cs`  out  1  active-low chip select.
- `data`  out  12  conversion result.
- `ch`  out  3  channel of `data`.
- `dv`  out  1  one-clock valid strobe.
- `busy`  out  1  scan in progress.
- `overrun`  out  1  sticky: a scan tick arrived while busy.

## Operation
- Tick generator: free-running counter 0..TPER-1 while `en`=1. It emits a one-clock `tick` at TPER-1. `en`=0 clears it.
- FSM states: IDLE → SETUP → XFER → GAP → (SETUP | IDLE).
- IDLE: `cs`=1. On `tick` with at least one enabled channel: latch `ch_mask`, select the lowest enabled channel, go to SETUP. With mask 0, the tick is ignored.
- SETUP: one clock. `cs` goes low, `mosi` = start bit, SCK phase counter cleared. Go to XFER.
- XFER: 19 SCK cycles, indexed k=0..18. Each SCK cycle is SCK_DIV clocks: low for SCK_DIV/2, then high.
  - MOSI changes only while SCK is low:
    - k0 = 1 (start)
    - k1 = SGL (~DIFF)
    - k2..k4 = D2, D1, D0 of the channel
    - k≥5 = 0
  - k5 is the sample period. k6 is the null bit and is discarded.
  - k7..k18 carry B11..B0. `miso` is registered on the clk edge where `sck` rises.
  - After the last clock of k18: go to GAP. `cs`=1, `sck`=0, and `dv`=1 for one clock with `data` and `ch`.
- GAP: `cs` high for TCSH_CLKS clocks, then go to SETUP for the next enabled channel, or to IDLE if none remain.
- `busy` = 1 outside IDLE.
- `tick` while busy: set `overrun`, drop the tick. The current scan finishes unchanged. Only reset clears `overrun`.
- `en` falling mid-scan: the current conversion and scan complete. No new ticks follow.
- `ch_mask` changes take effect at the next scan only.

## Timing
- Reset values: `cs`=1, `sck`=0, `mosi`=0, `data`=0, `ch`=0, `dv`=0, `busy`=0, `overrun`=0. FSM in IDLE, all counters 0.
- Reset asserted mid-XFER: outputs return to reset values immediately (asynchronous). No `dv` is produced.
- Latency:
  - `tick` → `cs` low: 1 clock.
  - `cs` low → `dv`: 1 + 19·SCK_DIV clocks.
  - `cs` high between channels: exactly TCSH_CLKS + 1 clocks.
- Per-channel cost: `C = 19·SCK_DIV + TCSH_CLKS + 2` clocks. A full mask needs N·C < TPER, otherwise `overrun` sets.
- Widths:
  - Phase counter: `$clog2(SCK_DIV)` bits.
  - k counter: 5 bits.
  - Period counter: `$clog2(TPER)` bits.
  - `data` is unsigned.

## Structure
- `mcp320x_pkg` holds:
  - state enum;
  - `FRAME_SCK=19`, `CMD_BITS=5`, `DATA_LSB_K=18`;
  - function `next_ch(mask, cur)` returning the next enabled channel or a done flag.
- Sub-module `mcp320x_tick_gen` (parameter TPER; ports `clk`, `rst_n`, `en`, `tick`).

## Test plan
- SCK_DIV=4, NCH=1, DIFF=0, `miso` model returns 0xA5C on ch0 → one `dv` with `data`=0xA5C, `ch`=0. `mosi` bits k0..k4 = 1,1,0,0,0. 19 SCK rising edges per `cs` low.
- NCH=4, `ch_mask`=8'b0000_1010 → exactly two `dv` pulses, `ch`=1 then `ch`=3. `cs` high exactly TCSH_CLKS+1 clocks between them. `busy` drops after the second pulse.
- DIFF=1, ch 6 → `mosi` k0..k4 = 1,0,1,1,0.
- TPER smaller than one conversion (FSMPL raised) → `overrun`=1 after the second tick. Results remain correct and ordered.
- Reset pulsed at k=10 → `cs`=1, `sck`=0 within the same clock. No `dv`. The next tick after reset starts a clean frame with the start bit.
- `ch_mask`=0 with `en`=1 → `cs` stays high and `busy`=0 across 3 periods.
